// File: rtl/galois_inv_fermat_sync.sv
// BN254 field inverter: a^-1 = a^(P-2) mod P by left-to-right square-and-multiply,
// driving a single fixed-latency Barrett multiplier. Also holds that multiplier.

// Fixed-latency modular multiplier: product = num1*num2 mod P, MULT_LAT cycles after operands.
// Data pipeline is deliberately unreset; only the valid tracker is.
module galois_mult_barrett_sync #(
   parameter int unsigned       N_BITS   = 254,
   parameter int unsigned       MULT_LAT = 16,
   parameter logic [N_BITS-1:0] P        = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [N_BITS-1:0] num1,
   input  logic [N_BITS-1:0] num2,
   output logic [N_BITS-1:0] product,
   output logic              ready
);
   localparam int unsigned XW  = 2 * N_BITS;        // full product
   localparam int unsigned XW1 = 2 * N_BITS + 1;    // holds 2^(2k)
   localparam int unsigned MUW = N_BITS + 1;        // Barrett constant (P has its top bit set)
   localparam int unsigned QW  = 2 * MUW;           // q1 * mu
   localparam int unsigned RW  = N_BITS + 2;        // remainder before correction, < 3P
   localparam int unsigned DLY = MULT_LAT - 6;      // padding after the 6 arithmetic stages

   localparam logic [XW1-1:0] R2K     = XW1'(1) << (2 * N_BITS);
   localparam logic [XW1-1:0] MU_FULL = R2K / XW1'(P);
   localparam logic [MUW-1:0] MU      = MUW'(MU_FULL);

   logic [N_BITS-1:0] s1_a, s1_b;
   logic [XW-1:0]     s2_x, s3_x;
   logic [QW-1:0]     s3_q2;
   logic [RW-1:0]     s4_r, s5_r;
   logic [N_BITS-1:0] s6_r;
   logic [N_BITS-1:0] dly [DLY];
   logic [MULT_LAT-1:0] vld;

   // Arithmetic pipeline: capture, multiply, quotient estimate, remainder, two corrections
   always_ff @(posedge clk) begin
      s1_a  <= num1;
      s1_b  <= num2;
      s2_x  <= XW'(s1_a) * XW'(s1_b);
      s3_x  <= s2_x;
      s3_q2 <= QW'(s2_x[XW-1:N_BITS-1]) * QW'(MU);
      s4_r  <= RW'(s3_x) - RW'(RW'(s3_q2[QW-1:N_BITS+1]) * RW'(P));
      s5_r  <= (s4_r >= RW'(P)) ? (s4_r - RW'(P)) : s4_r;
      s6_r  <= N_BITS'((s5_r >= RW'(P)) ? (s5_r - RW'(P)) : s5_r);
   end

   // Delay line padding the result out to the fixed latency
   always_ff @(posedge clk) begin
      dly[0] <= s6_r;
      for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
   end

   assign product = dly[DLY-1];

   // Valid tracker alongside the data pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld <= '0;
      else        vld <= {vld[MULT_LAT-2:0], valid_in};
   end

   assign ready = vld[MULT_LAT-1];
endmodule

module galois_inv_fermat_sync #(
   parameter int unsigned       N_BITS   = 254,
   parameter int unsigned       MULT_LAT = 16,
   parameter logic [N_BITS-1:0] P        = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N_BITS-1:0] a_in,
   output logic              busy,
   output logic              done,
   output logic              err_zero,
   output logic [N_BITS-1:0] result
);
   localparam int unsigned       IW = $clog2(N_BITS);
   localparam int unsigned       CW = $clog2(MULT_LAT + 1);
   localparam logic [N_BITS-1:0] E  = P - N_BITS'(2);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SQ_ISSUE  = 3'd1,
      SQ_WAIT   = 3'd2,
      MUL_ISSUE = 3'd3,
      MUL_WAIT  = 3'd4,
      FIN       = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic [N_BITS-1:0] a_q, a_nxt;
   logic [N_BITS-1:0] acc, acc_nxt;
   logic [N_BITS-1:0] num1, num1_nxt;
   logic [N_BITS-1:0] num2, num2_nxt;
   logic [N_BITS-1:0] result_nxt;
   logic [N_BITS-1:0] product;
   logic [IW-1:0]     bit_idx, bit_idx_nxt;
   logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
   logic              busy_nxt, done_nxt, err_zero_nxt;
   logic              err_pend, err_pend_nxt;
   logic              mult_go_c;
   logic              mult_ready_unused;

   // Marks the first cycle operands sit on the multiplier inputs
   assign mult_go_c = ((state == SQ_WAIT) || (state == MUL_WAIT)) && (wait_cnt == '0);

   galois_mult_barrett_sync #(
      .N_BITS   (N_BITS),
      .MULT_LAT (MULT_LAT),
      .P        (P)
   ) u_mult (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (mult_go_c),
      .num1     (num1),
      .num2     (num2),
      .product  (product),
      .ready    (mult_ready_unused)
   );

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_q      <= '0;
         acc      <= '0;
         num1     <= '0;
         num2     <= '0;
         bit_idx  <= '0;
         wait_cnt <= '0;
         err_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_zero <= 1'b0;
         result   <= '0;
      end else begin
         state    <= state_nxt;
         a_q      <= a_nxt;
         acc      <= acc_nxt;
         num1     <= num1_nxt;
         num2     <= num2_nxt;
         bit_idx  <= bit_idx_nxt;
         wait_cnt <= wait_cnt_nxt;
         err_pend <= err_pend_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         err_zero <= err_zero_nxt;
         result   <= result_nxt;
      end
   end

   // Next-state and datapath updates for the exponent scan
   always_comb begin
      state_nxt    = state;
      a_nxt        = a_q;
      acc_nxt      = acc;
      num1_nxt     = num1;
      num2_nxt     = num2;
      bit_idx_nxt  = bit_idx;
      wait_cnt_nxt = wait_cnt;
      err_pend_nxt = err_pend;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      err_zero_nxt = err_zero;
      result_nxt   = result;

      unique case (state)
         IDLE: begin
            if (start) begin
               if (a_in != '0) begin
                  // Top exponent bit is 1, so the accumulator starts at a
                  a_nxt        = a_in;
                  acc_nxt      = a_in;
                  bit_idx_nxt  = IW'(N_BITS - 2);
                  busy_nxt     = 1'b1;
                  err_pend_nxt = 1'b0;
                  state_nxt    = SQ_ISSUE;
               end else begin
                  err_pend_nxt = 1'b1;
                  state_nxt    = FIN;
               end
            end
         end
         SQ_ISSUE: begin
            num1_nxt     = acc;
            num2_nxt     = acc;
            wait_cnt_nxt = '0;
            state_nxt    = SQ_WAIT;
         end
         SQ_WAIT: begin
            if (wait_cnt == CW'(MULT_LAT)) begin
               acc_nxt = product;
               if (E[bit_idx]) begin
                  state_nxt = MUL_ISSUE;
               end else if (bit_idx == '0) begin
                  state_nxt = FIN;
               end else begin
                  bit_idx_nxt = bit_idx - IW'(1);
                  state_nxt   = SQ_ISSUE;
               end
            end else begin
               wait_cnt_nxt = wait_cnt + CW'(1);
            end
         end
         MUL_ISSUE: begin
            num1_nxt     = acc;
            num2_nxt     = a_q;
            wait_cnt_nxt = '0;
            state_nxt    = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (wait_cnt == CW'(MULT_LAT)) begin
               acc_nxt = product;
               if (bit_idx == '0) begin
                  state_nxt = FIN;
               end else begin
                  bit_idx_nxt = bit_idx - IW'(1);
                  state_nxt   = SQ_ISSUE;
               end
            end else begin
               wait_cnt_nxt = wait_cnt + CW'(1);
            end
         end
         FIN: begin
            result_nxt   = err_pend ? '0 : acc;
            err_zero_nxt = err_pend;
            done_nxt     = 1'b1;
            busy_nxt     = 1'b0;
            state_nxt    = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end
endmodule
